locked_regfile: RTL and testbench
=================================

// Module: locked_regfile
// PURPOSE
//   Parametrised register file with per-register write locks, N read ports, one write-back port.
//   A decode stage reserves its destination register before issue.
//   Readers of a locked register stall until write-back releases the lock.
//   Sits between the decode (rf read/reserve) and write-back pipeline stages.
//   It replaces the single global rf_can_rw flag with per-register hazard tracking and flush.
// PARAMETERS
//   DATA_W    32  register data width
//   ADDR_W    5   register index width; NUM_REGS = 2**ADDR_W
//   NUM_RD    2   number of read ports
//   ZERO_REG  1   1: register 0 reads 0, is never locked, and ignores writes
// PORTS
//   clk            in   1              single clock, rising edge
//   reset_n        in   1              asynchronous, active-low reset
//   rd_valid       in   NUM_RD         read request per port
//   rd_addr        in   NUM_RD*ADDR_W  read index, port p at [p*ADDR_W +: ADDR_W]
//   rd_ready       out  NUM_RD         read data usable this cycle
//   rd_data        out  NUM_RD*DATA_W  read data, combinational
//   res_valid      in   1              request to lock destination res_addr
//   res_addr       in   ADDR_W         register to lock
//   res_ready      out  1              lock accepted when res_valid && res_ready
//   wr_valid       in   1              write-back; always accepted (no ready)
//   wr_addr        in   ADDR_W         write index
//   wr_data        in   DATA_W         write value
//   flush          in   1              clear all locks (squash); data untouched
//   busy_cnt       out  ADDR_W+1       number of currently locked registers
//   err_unlocked_wr out 1              1-cycle pulse: write to an unlocked register
// BEHAVIOUR
//   Reset (async assert, sync release): all data regs = 0, all locks clear.
//     busy_cnt = 0, err_unlocked_wr = 0, res_ready = 1 (unless flush).
//   Read (combinational, 0-cycle latency), per port p:
//     rd_ready[p] = !locked[a] || (wr_valid && wr_addr == a).
//     rd_data: wr_data if bypass hit, else regs[a]. ZERO_REG && a==0: rd_ready=1, rd_data=0.
//     rd_ready does not depend on rd_valid; rd_valid only qualifies the read (no side effects).
//   Reserve: res_ready = !flush && (!locked[res_addr] || (wr_valid && wr_addr == res_addr)).
//     Fire (res_valid && res_ready) sets locked[res_addr] at the next edge.
//     Same-cycle write + reserve of one register: data written and lock stays set (re-locked).
//     ZERO_REG && res_addr==0: res_ready=1; the reservation has no effect.
//   Write: wr_valid writes regs[wr_addr] <= wr_data and clears locked[wr_addr] at the edge.
//     If that register was not locked, the write is still done and err_unlocked_wr pulses
//     the next cycle. Writes to reg 0 with ZERO_REG are ignored with no error.
//   Flush: all locks clear at the edge; res_ready=0 that cycle, so no reservation is lost
//     silently. A write in the flush cycle is performed, with no error pulse.
//   busy_cnt: registered popcount of the lock vector, updated the same edge as the locks.
//     Range 0..NUM_REGS.
//   Port order: read ports are independent; any number of ports may hit the same address.
// STRUCTURE
//   Package pdl_rf_pkg: rf_addr_t / rf_data_t typedefs and the ZERO_IDX constant.
//   Sub-module rf_lock_table:
//     - owns the lock vector, set/clear/flush priority, popcount and error detect.
//   Top level holds the data array, bypass muxes and the generate loop over read ports.
// TESTING
//   1 Reset mid-run with locks set -> busy_cnt=0, all rd_ready=1, reg 5 reads 0.
//   2 Reserve r3; next cycle read r3 -> rd_ready=0. Write r3=0xDEAD -> same cycle
//     rd_ready=1, rd_data=0xDEAD. Next cycle lock clear, busy_cnt=0.
//   3 Write r7 and reserve r7 same cycle -> res_ready=1, regs[7] updated, r7 still locked,
//     busy_cnt=1.
//   4 Lock r1, r2, r4 (busy_cnt=3). Assert flush with res_valid on r9 -> res_ready=0,
//     then busy_cnt=0 and r9 unlocked.
//   5 Write r6 while unlocked -> err_unlocked_wr=1 for exactly one cycle, regs[6] updated.
//   6 ZERO_REG=1: reserve r0, write r0=0x1234 -> r0 reads 0, rd_ready=1, no error,
//     busy_cnt=0. With NUM_RD=4, all ports reading r0 in parallel -> all return 0.

Source files
------------

// File: rtl/pdl_rf_pkg.sv
// pdl_rf_pkg: shared types and constants for the locked register file.
//   rf_data_t / rf_addr_t : default-width data word and register index.
//   ZERO_IDX              : index of the hard-wired zero register.
package pdl_rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    typedef logic [RF_DATA_W-1:0] rf_data_t;
    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

    localparam int ZERO_IDX = 0;

endpackage

// File: rtl/rf_lock_table.sv
// rf_lock_table: per-register lock vector for the locked register file.
//   Tracks which registers have an outstanding reservation, with the
//   priority flush > reserve > write-back clear. Also produces a registered
//   popcount of the locks and a one-cycle error pulse for write-backs that
//   hit a register that was not locked.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   res_fire, res_addr accepted reservation (already qualified by caller)
//   wr_en, wr_addr     effective write-back (zero register already masked)
//   flush              clear every lock at the next edge
//   locked             current lock vector, one bit per register
//   busy_cnt           number of locked registers
//   err_unlocked_wr    pulse: previous cycle wrote an unlocked register
module rf_lock_table #(
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 res_fire,
    input  logic [ADDR_W-1:0]    res_addr,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic                 flush,
    output logic [2**ADDR_W-1:0] locked,
    output logic [ADDR_W:0]      busy_cnt,
    output logic                 err_unlocked_wr
);

    logic [2**ADDR_W-1:0] lock_next;
    logic [ADDR_W:0]      cnt_next;
    logic                 err_next;

    always_comb begin
        lock_next = locked;
        // Reservation is applied after the write-back clear so a same-cycle
        // write and reserve of one register leaves it locked again.
        if (wr_en) begin
            lock_next[wr_addr] = 1'b0;
        end
        if (res_fire) begin
            lock_next[res_addr] = 1'b1;
        end
        if (flush) begin
            lock_next = '0;
        end

        cnt_next = '0;
        for (int i = 0; i < 2**ADDR_W; i++) begin
            cnt_next = cnt_next + {{ADDR_W{1'b0}}, lock_next[i]};
        end

        // A write-back during flush is a squash artefact, not a hazard error.
        err_next = wr_en && !flush && !locked[wr_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked          <= '0;
            busy_cnt        <= '0;
            err_unlocked_wr <= 1'b0;
        end else begin
            locked          <= lock_next;
            busy_cnt        <= cnt_next;
            err_unlocked_wr <= err_next;
        end
    end

endmodule

// File: rtl/locked_regfile.sv
// locked_regfile: register file with per-register write locks.
//   Decode reserves its destination before issue; readers of a locked
//   register see rd_ready=0 until write-back releases the lock. A
//   write-back in the same cycle is bypassed to readers and reservers.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   rd_valid/rd_addr    NUM_RD read requests, port p at [p*ADDR_W +: ADDR_W]
//   rd_ready/rd_data    per-port combinational ready and data
//   res_valid/res_addr  lock request; accepted when res_ready is high
//   res_ready           reservation can be accepted this cycle
//   wr_valid/wr_addr/wr_data  write-back, always accepted
//   flush               clear all locks; register data is untouched
//   busy_cnt            number of locked registers
//   err_unlocked_wr     pulse after a write-back to an unlocked register
module locked_regfile
    import pdl_rf_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_RD-1:0]        rd_valid,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_ready,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     res_valid,
    input  logic [ADDR_W-1:0]        res_addr,
    output logic                     res_ready,
    input  logic                     wr_valid,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt,
    output logic                     err_unlocked_wr
);

    localparam int  NUM_REGS = 2**ADDR_W;
    localparam bit  ZERO_EN  = (ZERO_REG != 0);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] locked;
    logic                res_zero;
    logic                wr_zero;
    logic                res_fire;
    logic                wr_en;

    // rd_valid only qualifies a read for the consumer; reads have no side
    // effects here, so it is intentionally not used.
    logic unused_rd_valid;
    assign unused_rd_valid = ^rd_valid;

    assign res_zero = ZERO_EN && (res_addr == ADDR_W'(ZERO_IDX));
    assign wr_zero  = ZERO_EN && (wr_addr == ADDR_W'(ZERO_IDX));

    // Flush blocks every reservation so none is silently dropped.
    assign res_ready = !flush &&
                       (res_zero || !locked[res_addr] ||
                        (wr_valid && (wr_addr == res_addr)));

    // Zero-register reservations and writes are accepted but have no effect.
    assign res_fire = res_valid && res_ready && !res_zero;
    assign wr_en    = wr_valid && !wr_zero;

    rf_lock_table #(
        .ADDR_W (ADDR_W)
    ) u_lock_table (
        .clk             (clk),
        .reset_n         (reset_n),
        .res_fire        (res_fire),
        .res_addr        (res_addr),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .flush           (flush),
        .locked          (locked),
        .busy_cnt        (busy_cnt),
        .err_unlocked_wr (err_unlocked_wr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              hit;
        logic              zero;

        assign a    = rd_addr[p*ADDR_W +: ADDR_W];
        assign hit  = wr_valid && (wr_addr == a);
        assign zero = ZERO_EN && (a == ADDR_W'(ZERO_IDX));

        assign rd_ready[p] = zero || !locked[a] || hit;
        assign rd_data[p*DATA_W +: DATA_W] = zero ? '0 : (hit ? wr_data : regs[a]);
    end

endmodule

// File: tb/tb_locked_regfile.sv
module tb_locked_regfile;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  rd_valid;
    logic [9:0]  rd_addr;
    logic [1:0]  rd_ready;
    logic [63:0] rd_data;
    logic        res_valid;
    logic [4:0]  res_addr;
    logic        res_ready;
    logic        wr_valid;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        flush;
    logic [5:0]  busy_cnt;
    logic        err_unlocked_wr;

    logic [3:0]   rd_valid4;
    logic [19:0]  rd_addr4;
    logic [3:0]   rd_ready4;
    logic [127:0] rd_data4;
    logic         res_ready4;
    logic [5:0]   busy_cnt4;
    logic         err4;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: register contents and lock set at the abstract level.
    logic [31:0] m_regs [32];
    bit          m_lock [32];
    bit          m_err;

    always #5 clk = ~clk;

    locked_regfile dut (
        .clk(clk), .reset_n(reset_n), .rd_valid(rd_valid), .rd_addr(rd_addr),
        .rd_ready(rd_ready), .rd_data(rd_data), .res_valid(res_valid),
        .res_addr(res_addr), .res_ready(res_ready), .wr_valid(wr_valid),
        .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush),
        .busy_cnt(busy_cnt), .err_unlocked_wr(err_unlocked_wr)
    );

    locked_regfile #(.NUM_RD(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .rd_valid(rd_valid4), .rd_addr(rd_addr4),
        .rd_ready(rd_ready4), .rd_data(rd_data4), .res_valid(res_valid),
        .res_addr(res_addr), .res_ready(res_ready4), .wr_valid(wr_valid),
        .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush),
        .busy_cnt(busy_cnt4), .err_unlocked_wr(err4)
    );

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_lock[i] = 0;
        end
        m_err = 0;
    endfunction

    function automatic bit m_rd_ready(input int a);
        if (a == 0) return 1;
        return !m_lock[a] || (wr_valid && int'(wr_addr) == a);
    endfunction

    function automatic logic [31:0] m_rd_data(input int a);
        if (a == 0) return 32'h0;
        if (wr_valid && int'(wr_addr) == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic bit m_res_ready();
        if (flush) return 0;
        return m_rd_ready(int'(res_addr));
    endfunction

    function automatic int m_busy();
        int c = 0;
        for (int i = 0; i < 32; i++) c += m_lock[i];
        return c;
    endfunction

    task automatic idle();
        rd_valid = '0; rd_addr = '0; rd_valid4 = '0; rd_addr4 = '0;
        res_valid = 0; res_addr = '0; wr_valid = 0; wr_addr = '0;
        wr_data = '0; flush = 0;
    endtask

    // Advance one rising edge and apply the same edge to the model.
    task automatic tick();
        bit fire;
        int wa;
        int ra;
        @(posedge clk);
        fire = res_valid && m_res_ready();
        wa = int'(wr_addr);
        ra = int'(res_addr);
        m_err = 0;
        if (wr_valid && wa != 0) begin
            m_regs[wa] = wr_data;
            m_err = !flush && !m_lock[wa];
            m_lock[wa] = 0;
        end
        if (fire && ra != 0) m_lock[ra] = 1;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_lock[i] = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        model_clear();
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (busy_cnt !== 6'd0) $display("FAIL reset_busy got=%0d exp=0", busy_cnt);
        else n_pass++;
        n_checks++;
        if (err_unlocked_wr !== 1'b0 || res_ready !== 1'b1)
            $display("FAIL reset_flags err=%b res_ready=%b exp err=0 res_ready=1", err_unlocked_wr, res_ready);
        else n_pass++;
        // Build state, then reset mid-run.
        res_valid = 1; res_addr = 5'd3; tick();
        res_addr = 5'd4; tick();
        res_valid = 0; wr_valid = 1; wr_addr = 5'd5; wr_data = 32'hCAFE_0005; tick();
        idle();
        n_checks++;
        if (busy_cnt !== 6'd2) $display("FAIL pre_reset_busy got=%0d exp=2", busy_cnt);
        else n_pass++;
        #2 reset_n = 0;
        rd_addr = {5'd3, 5'd5};
        #1;
        n_checks++;
        if (busy_cnt !== 6'd0 || rd_ready !== 2'b11)
            $display("FAIL async_reset busy=%0d rd_ready=%b exp busy=0 rd_ready=11", busy_cnt, rd_ready);
        else n_pass++;
        n_checks++;
        if (rd_data[31:0] !== 32'h0) $display("FAIL reset_r5_data got=%h exp=0", rd_data[31:0]);
        else n_pass++;
        @(negedge clk);
        reset_n = 1;
        model_clear();
        idle();
        #1;
    endtask

    task automatic test_reserve_bypass();
        res_valid = 1; res_addr = 5'd3; tick();
        idle(); rd_addr[4:0] = 5'd3; #1;
        n_checks++;
        if (rd_ready[0] !== 1'b0) $display("FAIL locked_read_ready got=%b exp=0", rd_ready[0]);
        else n_pass++;
        wr_valid = 1; wr_addr = 5'd3; wr_data = 32'h0000_DEAD; #1;
        n_checks++;
        if (rd_ready[0] !== 1'b1 || rd_data[31:0] !== 32'h0000_DEAD)
            $display("FAIL bypass ready=%b data=%h exp ready=1 data=0000dead", rd_ready[0], rd_data[31:0]);
        else n_pass++;
        tick();
        wr_valid = 0; #1;
        n_checks++;
        if (busy_cnt !== 6'd0 || err_unlocked_wr !== 1'b0)
            $display("FAIL release busy=%0d err=%b exp busy=0 err=0", busy_cnt, err_unlocked_wr);
        else n_pass++;
        n_checks++;
        if (rd_ready[0] !== 1'b1 || rd_data[31:0] !== 32'h0000_DEAD)
            $display("FAIL after_release ready=%b data=%h exp ready=1 data=0000dead", rd_ready[0], rd_data[31:0]);
        else n_pass++;
        idle();
    endtask

    task automatic test_write_reserve_same();
        res_valid = 1; res_addr = 5'd7;
        wr_valid = 1; wr_addr = 5'd7; wr_data = 32'h7777_0007; #1;
        n_checks++;
        if (res_ready !== 1'b1) $display("FAIL wr_res_ready got=%b exp=1", res_ready);
        else n_pass++;
        tick();
        idle(); rd_addr[9:5] = 5'd7; #1;
        n_checks++;
        if (busy_cnt !== 6'd1 || rd_ready[1] !== 1'b0)
            $display("FAIL relock busy=%0d ready=%b exp busy=1 ready=0", busy_cnt, rd_ready[1]);
        else n_pass++;
        n_checks++;
        if (rd_data[63:32] !== 32'h7777_0007) $display("FAIL relock_data got=%h exp=77770007", rd_data[63:32]);
        else n_pass++;
        wr_valid = 1; wr_addr = 5'd7; wr_data = 32'h7777_1007; tick();
        idle();
    endtask

    task automatic test_flush();
        res_valid = 1;
        res_addr = 5'd1; tick();
        res_addr = 5'd2; tick();
        res_addr = 5'd4; tick();
        idle(); #1;
        n_checks++;
        if (busy_cnt !== 6'd3) $display("FAIL flush_pre_busy got=%0d exp=3", busy_cnt);
        else n_pass++;
        flush = 1; res_valid = 1; res_addr = 5'd9;
        wr_valid = 1; wr_addr = 5'd12; wr_data = 32'h1200_0012; #1;
        n_checks++;
        if (res_ready !== 1'b0) $display("FAIL flush_res_ready got=%b exp=0", res_ready);
        else n_pass++;
        tick();
        idle(); rd_addr = {5'd12, 5'd9}; #1;
        n_checks++;
        if (busy_cnt !== 6'd0 || rd_ready !== 2'b11 || err_unlocked_wr !== 1'b0)
            $display("FAIL flush_post busy=%0d ready=%b err=%b exp busy=0 ready=11 err=0", busy_cnt, rd_ready, err_unlocked_wr);
        else n_pass++;
        n_checks++;
        if (rd_data[63:32] !== 32'h1200_0012) $display("FAIL flush_write got=%h exp=12000012", rd_data[63:32]);
        else n_pass++;
        idle();
    endtask

    task automatic test_unlocked_write();
        wr_valid = 1; wr_addr = 5'd6; wr_data = 32'h6666_0006; tick();
        idle(); rd_addr[4:0] = 5'd6; #1;
        n_checks++;
        if (err_unlocked_wr !== 1'b1) $display("FAIL err_pulse got=%b exp=1", err_unlocked_wr);
        else n_pass++;
        n_checks++;
        if (rd_data[31:0] !== 32'h6666_0006) $display("FAIL unlocked_data got=%h exp=66660006", rd_data[31:0]);
        else n_pass++;
        tick();
        n_checks++;
        if (err_unlocked_wr !== 1'b0) $display("FAIL err_one_cycle got=%b exp=0", err_unlocked_wr);
        else n_pass++;
        idle();
    endtask

    task automatic test_zero_reg();
        res_valid = 1; res_addr = 5'd0;
        wr_valid = 1; wr_addr = 5'd0; wr_data = 32'h0000_1234; #1;
        n_checks++;
        if (res_ready !== 1'b1) $display("FAIL zero_res_ready got=%b exp=1", res_ready);
        else n_pass++;
        tick();
        idle(); rd_addr = '0; rd_addr4 = '0; rd_valid = 2'b11; rd_valid4 = 4'hF; #1;
        n_checks++;
        if (busy_cnt !== 6'd0 || err_unlocked_wr !== 1'b0 || busy_cnt4 !== 6'd0 || err4 !== 1'b0)
            $display("FAIL zero_state busy=%0d err=%b busy4=%0d err4=%b exp all 0", busy_cnt, err_unlocked_wr, busy_cnt4, err4);
        else n_pass++;
        n_checks++;
        if (rd_ready !== 2'b11 || rd_data !== 64'h0)
            $display("FAIL zero_read ready=%b data=%h exp ready=11 data=0", rd_ready, rd_data);
        else n_pass++;
        n_checks++;
        if (rd_ready4 !== 4'hF || rd_data4 !== 128'h0)
            $display("FAIL zero_read4 ready=%b data=%h exp ready=1111 data=0", rd_ready4, rd_data4);
        else n_pass++;
        idle();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            int a;
            res_valid = ($urandom_range(0, 1) == 1);
            res_addr  = 5'($urandom_range(0, 31));
            wr_valid  = ($urandom_range(0, 2) == 0);
            // Bias write-backs towards locked registers to exercise release.
            a = $urandom_range(0, 31);
            for (int k = 0; k < 32; k++) begin
                if (m_lock[(a + k) % 32] && $urandom_range(0, 3) != 0) begin
                    a = (a + k) % 32;
                    break;
                end
            end
            wr_addr   = 5'(a);
            wr_data   = $urandom;
            flush     = ($urandom_range(0, 19) == 0);
            rd_valid  = 2'($urandom_range(0, 3));
            rd_valid4 = 4'($urandom_range(0, 15));
            for (int p = 0; p < 2; p++) rd_addr[p*5 +: 5] = 5'($urandom_range(0, 31));
            for (int p = 0; p < 4; p++) rd_addr4[p*5 +: 5] = 5'($urandom_range(0, 31));
            #1;
            for (int p = 0; p < 2; p++) begin
                n_checks++;
                if (rd_ready[p] !== m_rd_ready(int'(rd_addr[p*5 +: 5])) ||
                    rd_data[p*32 +: 32] !== m_rd_data(int'(rd_addr[p*5 +: 5])))
                    $display("FAIL rand_rd cyc=%0d port=%0d ready=%b data=%h exp ready=%b data=%h", cyc, p,
                             rd_ready[p], rd_data[p*32 +: 32], m_rd_ready(int'(rd_addr[p*5 +: 5])),
                             m_rd_data(int'(rd_addr[p*5 +: 5])));
                else n_pass++;
            end
            for (int p = 0; p < 4; p++) begin
                n_checks++;
                if (rd_ready4[p] !== m_rd_ready(int'(rd_addr4[p*5 +: 5])) ||
                    rd_data4[p*32 +: 32] !== m_rd_data(int'(rd_addr4[p*5 +: 5])))
                    $display("FAIL rand_rd4 cyc=%0d port=%0d ready=%b data=%h", cyc, p,
                             rd_ready4[p], rd_data4[p*32 +: 32]);
                else n_pass++;
            end
            n_checks++;
            if (res_ready !== m_res_ready()) $display("FAIL rand_res_ready cyc=%0d got=%b exp=%b", cyc, res_ready, m_res_ready());
            else n_pass++;
            tick();
            n_checks++;
            if (busy_cnt !== 6'(m_busy()) || err_unlocked_wr !== m_err)
                $display("FAIL rand_state cyc=%0d busy=%0d err=%b exp busy=%0d err=%b", cyc, busy_cnt, err_unlocked_wr, m_busy(), m_err);
            else n_pass++;
        end
        idle();
    endtask

    initial begin
        model_clear();
        idle();
        reset_n = 1;
        #2;
        test_reset();
        test_reserve_bypass();
        test_write_reserve_same();
        test_flush();
        test_unlocked_write();
        test_zero_reg();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
